core_fetch_ctrl: RTL
====================

// Module: core_fetch_ctrl
// PURPOSE
//  Fetch sequencer between the PC/IF datapath and the instruction-memory port.
//  - Owns the fetch PC and issues in-order imem requests over a valid/ready handshake.
//  - Tracks up to MAX_OUTST in-flight requests and buffers their responses.
//  - Kills wrong-path fetches on redirect; hands instructions to decode via valid/ready.
// PARAMETERS
//  XLEN       32      address/PC width
//  ILEN       32      instruction width
//  MAX_OUTST  2       tracking-FIFO depth (in-flight + buffered), power of 2, >=2
//  RESET_PC   32'h0   first fetch address after reset
// PORTS
//  i_clk            in   1     clock
//  i_rst_n          in   1     reset, asynchronous, active-low
//  i_redirect       in   1     branch/flush redirect, single-cycle pulse
//  i_redirect_pc    in   XLEN  redirect target; bits [1:0] forced to 0
//  o_imem_req_valid out  1     request valid
//  i_imem_req_ready in   1     memory accepts request
//  o_imem_req_addr  out  XLEN  request address (= fetch PC)
//  i_imem_rsp_valid in   1     response valid; no backpressure, always accepted
//  i_imem_rsp_data  in   ILEN  response instruction word
//  o_instr_valid    out  1     instruction valid to decode
//  i_instr_ready    in   1     decode accepts instruction
//  o_instr          out  ILEN  instruction
//  o_instr_pc       out  XLEN  PC of o_instr
//  o_rsp_err        out  1     sticky: response arrived with no request outstanding
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, fetch PC=RESET_PC, state RUN. First request
//   (addr RESET_PC) is presented in the first cycle after reset release.
//  Tracking FIFO entry {pc, data, filled, kill}. A request handshake pushes {pc,0,0,0}.
//  Responses fill the oldest unfilled entry (in order); data is registered.
//  Head entry filled & ~kill -> o_instr_valid=1 (~i_redirect), o_instr/o_instr_pc from head.
//  Pop on valid&ready. A filled, killed head pops silently, one per cycle.
//  Earliest o_instr_valid is 1 cycle after the response cycle.
//  FSM (fetch_state_e):
//   RUN:  req_valid=1 when FIFO not full.
//    - ready=1: PC+=4, stay.
//    - ready=0: ->HOLD.
//    - i_redirect: PC<=redirect_pc; issue at new PC next cycle.
//   HOLD: valid held; addr stable until ready.
//    - ready: PC+=4, ->RUN.
//    - i_redirect without ready: latch target ->RPEND.
//    - i_redirect with ready: accepted entry pushed killed, PC<=target, ->RUN.
//   RPEND: old request still held.
//    - ready: entry pushed killed, PC<=pending target, ->RUN.
//    - A new redirect overwrites the pending target.
//  Redirect: sets kill on every existing entry, plus any entry pushed the same cycle.
//   o_instr_valid is forced 0 in the redirect cycle (no handshake).
//  Simultaneous events:
//   - redirect+response: the filled entry is killed.
//   - pop+push on a full FIFO: allowed only when the pop is not throttled;
//     full is checked against the registered count.
//  rsp_valid with zero unfilled entries: ignored, o_rsp_err<=1 (cleared only by reset).
//  PC arithmetic modulo 2^XLEN; wrap 0xFFFF_FFFC -> 0 is legal.
//  Reset mid-operation: asynchronous clear.
//   - Responses arriving after release for pre-reset requests raise o_rsp_err.
// STRUCTURE
//  core_fetch_pkg: fetch_state_e {RUN,HOLD,RPEND}, fetch_entry_t struct,
//   PC_INC=4, ALIGN_MASK.
//  Sub-module fetch_track_fifo: MAX_OUTST entries with push/fill/pop/kill-all
//   and full/empty/unfilled count.
//  Top level holds the FSM, PC, and pending-target registers.
// TESTING
//  1. Reset release, ready=1, rsp 1 cycle later with 0x13 -> reqs 0x0,0x4,0x8;
//     instr 0x13 @pc 0x0 valid 1 cycle after rsp.
//  2. ready=0 for 3 cycles -> addr held 0x4, no PC advance; ready=1 -> next req 0x8.
//  3. Two reqs in flight, redirect to 0x100 -> both rsps dropped, no valid;
//     next req addr 0x100.
//  4. HOLD + redirect 0x200, ready 2 cycles later -> old req accepted and killed;
//     next req 0x200.
//  5. Decode ready=0, MAX_OUTST=2 filled -> req_valid=0 until pop; then resumes.
//  6. rsp_valid with empty FIFO -> o_rsp_err=1, no o_instr_valid;
//     sticky until i_rst_n=0.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package core_fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned FETCH_ILEN = 32;
  localparam int unsigned PC_INC     = 4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    RPEND = 2'd2
  } fetch_state_e;

  // One tracking slot at the default widths; the FIFO keeps these fields in parallel arrays.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] data;
    logic                  filled;
    logic                  kill;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_ctrl_track_fifo.sv
// In-order tracking FIFO for fetch requests: push on issue, fill on response,
// pop at the head, and a kill-all used by redirects.
module fetch_track_fifo
  import core_fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_pc,
  input  logic            i_push_kill,
  input  logic            i_fill,
  input  logic [ILEN-1:0] i_fill_data,
  input  logic            i_pop,
  input  logic            i_kill_all,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_unfilled,
  output logic            o_head_filled,
  output logic            o_head_kill,
  output logic [XLEN-1:0] o_head_pc,
  output logic [ILEN-1:0] o_head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [ILEN-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_nfilled;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_unfilled;
  logic          w_push_ok;
  logic          w_fill_ok;
  logic          w_pop_ok;
  logic [PW-1:0] w_fill_idx;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_unfilled = r_count - r_nfilled;
  assign w_push_ok  = i_push & ~w_full;
  assign w_fill_ok  = i_fill & (w_unfilled != '0);
  assign w_pop_ok   = i_pop & ~w_empty & r_filled[r_rd_ptr];
  // Filled entries are always a contiguous run starting at the head.
  assign w_fill_idx = r_rd_ptr + r_nfilled[PW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
      r_filled  <= '0;
      r_kill    <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
    end else begin
      if (i_kill_all) r_kill <= '1;
      if (w_fill_ok) begin
        r_data[w_fill_idx]   <= i_fill_data;
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (w_push_ok) begin
        r_pc[r_wr_ptr]     <= i_push_pc;
        r_data[r_wr_ptr]   <= '0;
        r_filled[r_wr_ptr] <= 1'b0;
        r_kill[r_wr_ptr]   <= i_push_kill | i_kill_all;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      r_nfilled <= r_nfilled + CW'(w_fill_ok) - CW'(w_pop_ok);
    end
  end

  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_unfilled    = w_unfilled;
  assign o_head_filled = r_filled[r_rd_ptr];
  assign o_head_kill   = r_kill[r_rd_ptr];
  assign o_head_pc     = r_pc[r_rd_ptr];
  assign o_head_data   = r_data[r_rd_ptr];

endmodule

// File: rtl/core_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues in-order imem requests, tracks
// them in a small FIFO and hands responses to decode, dropping wrong-path fetches.
//   state | meaning
//   RUN   | issuing a new request whenever the tracking FIFO has room
//   HOLD  | request presented but not accepted; address held
//   RPEND | held request now wrong-path; redirect target waits in r_pend_pc
module core_fetch_ctrl
  import core_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [ILEN-1:0] i_imem_rsp_data,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_rsp_err
);

  localparam int              CW       = $clog2(MAX_OUTST) + 1;
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(~ALIGN_MASK);

  fetch_state_e    r_state;
  logic            r_live;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_rsp_err;

  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_unfilled;
  logic            w_head_filled;
  logic            w_head_kill;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_data;

  logic            w_req_valid;
  logic            w_req_fire;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_pc_seq;
  logic            w_push_kill;
  logic            w_head_ready;
  logic            w_instr_valid;
  logic            w_pop;
  logic            w_rsp_orphan;

  // r_live keeps the request port quiet while reset is asserted.
  assign w_req_valid   = r_live & ((r_state != RUN) | ~w_full);
  assign w_req_fire    = w_req_valid & i_imem_req_ready;
  assign w_redir_pc    = i_redirect_pc & PC_ALIGN;
  assign w_pc_seq      = r_pc + XLEN'(PC_INC);
  assign w_push_kill   = i_redirect | (r_state == RPEND);
  assign w_head_ready  = w_head_filled & ~w_empty;
  assign w_instr_valid = w_head_ready & ~w_head_kill & ~i_redirect;
  assign w_pop         = (w_instr_valid & i_instr_ready) | (w_head_ready & w_head_kill);
  assign w_rsp_orphan  = i_imem_rsp_valid & (w_unfilled == '0);

  fetch_track_fifo #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (MAX_OUTST),
    .CW    (CW)
  ) u_track (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (w_req_fire),
    .i_push_pc     (r_pc),
    .i_push_kill   (w_push_kill),
    .i_fill        (i_imem_rsp_valid),
    .i_fill_data   (i_imem_rsp_data),
    .i_pop         (w_pop),
    .i_kill_all    (i_redirect),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_unfilled    (w_unfilled),
    .o_head_filled (w_head_filled),
    .o_head_kill   (w_head_kill),
    .o_head_pc     (w_head_pc),
    .o_head_data   (w_head_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RUN;
      r_live    <= 1'b0;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_rsp_orphan) r_rsp_err <= 1'b1;
      unique case (r_state)
        RUN: begin
          // An unaccepted request in the redirect cycle is simply dropped.
          if (i_redirect)       r_pc    <= w_redir_pc;
          else if (w_req_fire)  r_pc    <= w_pc_seq;
          else if (w_req_valid) r_state <= HOLD;
        end
        HOLD: begin
          if (i_imem_req_ready) begin
            r_pc    <= i_redirect ? w_redir_pc : w_pc_seq;
            r_state <= RUN;
          end else if (i_redirect) begin
            r_pend_pc <= w_redir_pc;
            r_state   <= RPEND;
          end
        end
        RPEND: begin
          if (i_imem_req_ready) begin
            r_pc    <= i_redirect ? w_redir_pc : r_pend_pc;
            r_state <= RUN;
          end else if (i_redirect) begin
            r_pend_pc <= w_redir_pc;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_instr_valid    = w_instr_valid;
  assign o_instr          = w_head_data;
  assign o_instr_pc       = w_head_pc;
  assign o_rsp_err        = r_rsp_err;

endmodule
